// File: rtl/dnn_accel_pio_led_pwm.sv
// dnn_accel_pio_led_pwm
//   Avalon-MM slave output port for board LEDs and status indicators.
//   Provides a WIDTH-bit data register with atomic set/clear aliases, a
//   per-bit blink mask driven by a programmable half-period prescaler, and
//   a global PWM brightness duty applied to every output bit.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     word address (0 DATA, 1 BLINK_EN, 2 PERIOD, 3 DUTY,
//               4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above the register width are ignored)
//   readdata    combinational read data, zero wait states
//   out_port    registered LED drive

module dnn_accel_pio_led_pwm #(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 24,
    parameter int PWM_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_en_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PWM_W-1:0]    duty_q;

    logic [PERIOD_W-1:0] pcnt;
    logic                phase;
    logic [PWM_W-1:0]    pwm_cnt;
    logic                pwm_on;

    logic                wr;
    logic [WIDTH-1:0]    wd_data;
    logic                unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_en_q <= '0;
            period_q   <= '0;
            duty_q     <= '1;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_q     <= wd_data;
                ADDR_BLINK_EN: blink_en_q <= wd_data;
                ADDR_PERIOD:   period_q   <= writedata[PERIOD_W-1:0];
                ADDR_DUTY:     duty_q     <= writedata[PWM_W-1:0];
                ADDR_OUTSET:   data_q     <= data_q | wd_data;
                ADDR_OUTCLEAR: data_q     <= data_q & ~wd_data;
                default:       ;
            endcase
        end
    end

    // Read mux; the set/clear aliases read back DATA
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_DUTY:     readdata = 32'(duty_q);
            ADDR_OUTSET:   readdata = 32'(data_q);
            ADDR_OUTCLEAR: readdata = 32'(data_q);
            default:       readdata = '0;
        endcase
    end

    // Blink prescaler. A PERIOD write restarts the half-period with the
    // LEDs lit, so a new rate takes effect cleanly from that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (wr && address == ADDR_PERIOD) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (period_q == '0) begin
            pcnt  <= '0;
            phase <= 1'b1;
        end else if (pcnt == period_q) begin
            pcnt  <= '0;
            phase <= ~phase;
        end else begin
            pcnt  <= pcnt + 1'b1;
        end
    end

    // Free-running PWM counter; all-ones duty is forced fully on so that
    // the reset value gives full brightness.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_on = (duty_q == {PWM_W{1'b1}}) || (pwm_cnt < duty_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= data_q & (~blink_en_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};
        end
    end

endmodule

// File: tb/tb_dnn_accel_pio_led_pwm.sv
// Testbench for dnn_accel_pio_led_pwm (WIDTH=8, PERIOD_W=24, PWM_W=8).
// Stimulus pushes expected out_port/readdata values tagged with the cycle in
// which they must hold; a monitor pops and compares them at the falling edge.

module tb_dnn_accel_pio_led_pwm;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    dnn_accel_pio_led_pwm #(
        .WIDTH    (8),
        .PERIOD_W (24),
        .PWM_W    (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          sel_rd;
        logic [31:0] exp;
        logic [63:0] tag;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic [63:0] name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            if (e.cyc < cyc)
                check("stale", 32'(e.cyc), 32'(cyc));
            else if (e.sel_rd)
                check(e.tag, readdata, e.exp);
            else
                check(e.tag, {24'h0, out_port}, e.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic exp_out(input logic [63:0] tag, input logic [7:0] v);
        sb_t e;
        e.cyc = cyc; e.sel_rd = 1'b0; e.exp = {24'h0, v}; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input logic [63:0] tag, input logic [2:0] a, input logic [31:0] v);
        sb_t e;
        address = a;
        e.cyc = cyc; e.sel_rd = 1'b1; e.exp = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic count_high(input logic [63:0] tag, input int exp_cnt);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            if (out_port[0]) n++;
            tick();
        end
        check(tag, 32'(n), 32'(exp_cnt));
    endtask

    function automatic logic [7:0] blink3(input int j);
        if (j == 0) return 8'hFF;
        return (((j - 1) / 4) % 2 == 0) ? 8'hFF : 8'hF0;
    endfunction

    function automatic logic [7:0] blink1(input int j);
        if (j == 0) return 8'hF0;
        return (((j - 1) / 2) % 2 == 0) ? 8'hFF : 8'hF0;
    endfunction

    logic [31:0] rst_vals [8];

    initial begin
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0};
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        exp_out("rst_out", 8'h00);
        exp_rd("rst_d0", 3'd0, 32'h0);
        tick();
        exp_rd("rst_dty", 3'd3, 32'hFF);
        tick();

        // Write with chipselect low is ignored
        address   = 3'd0;
        writedata = 32'h55;
        write_n   = 1'b0;
        tick();
        write_n = 1'b1;
        exp_rd("cs_low", 3'd0, 32'h0);
        tick();

        // DATA write latency
        wr(3'd0, 32'hFFFF_FFA5);
        exp_rd("data_rd", 3'd0, 32'hA5);
        exp_out("data_n", 8'h00);
        tick();
        exp_out("data_n1", 8'hA5);
        tick();

        // Set / clear
        wr(3'd0, 32'hF0);
        tick();
        wr(3'd4, 32'h0F);
        exp_rd("set_rd", 3'd4, 32'hFF);
        exp_out("set_n", 8'hF0);
        tick();
        exp_out("set_n1", 8'hFF);
        exp_rd("set_d0", 3'd0, 32'hFF);
        wr(3'd5, 32'h81);
        exp_rd("clr_rd", 3'd5, 32'h7E);
        exp_out("clr_n", 8'hFF);
        tick();
        exp_out("clr_n1", 8'h7E);
        exp_rd("res_rd", 3'd6, 32'h0);
        tick();

        // Blink, PERIOD=3, then PERIOD=1 mid-period
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h3);
        for (int j = 0; j <= 6; j++) begin
            exp_out("blink3", blink3(j));
            if (j < 6) tick();
        end
        wr(3'd2, 32'h1);
        for (int j = 0; j <= 8; j++) begin
            exp_out("blink1", blink1(j));
            tick();
        end

        // PWM
        wr(3'd1, 32'h0);
        wr(3'd2, 32'h0);
        wr(3'd0, 32'h01);
        wr(3'd3, 32'h40);
        exp_rd("duty_rd", 3'd3, 32'h40);
        tick();
        tick();
        count_high("pwm64", 64);
        wr(3'd3, 32'h0);
        tick();
        count_high("pwm0", 0);
        wr(3'd3, 32'hFF);
        tick();
        count_high("pwm255", 256);

        // Asynchronous reset mid-blink
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h2);
        repeat (5) tick();
        check("pre_rst", {24'h0, out_port[7:4], 4'h0}, 32'hF0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out", {24'h0, out_port}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            exp_rd("post_rst", 3'(a), rst_vals[a]);
            exp_out("post_out", 8'h00);
            tick();
        end

        // Blink prescaler restarts from reset values
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'h3);
        for (int j = 0; j <= 6; j++) begin
            exp_out("blinkrr", blink3(j));
            tick();
        end

        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
